// File: rtl/temporizador_9b_if.sv
// temporizador_9b_if: control/status bundle of the 9-bit down-counter timer.
// master drives load/value/sub, slave (the timer) returns the count and flags.
`default_nettype none

interface temporizador_9b_if #(
   parameter int WIDTH = 9
);
   logic             load;
   logic [WIDTH-1:0] value;
   logic             sub;
   logic [WIDTH-1:0] s;
   logic             zero;
   logic             busy;
   logic             done;

   modport master (
      output load, value, sub,
      input  s, zero, busy, done
   );

   modport slave (
      input  load, value, sub,
      output s, zero, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/temporizador_9b.sv
// ============================================================================
// Module   : temporizador_9b
// Function : loadable down-counter/timer with prescaled decrement, saturates at
//            zero and pulses done once on expiry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module temporizador_9b #(
   parameter int WIDTH    = 9,
   parameter int TICK_DIV = 1
) (
   input  wire logic           clk,
   input  wire logic           reset,
   temporizador_9b_if.slave    bus
);
   localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [c_PW-1:0]  c_PRE_MAX  = c_PW'(TICK_DIV - 1);
   localparam logic [c_PW-1:0]  c_PRE_ONE  = 1;
   localparam logic [WIDTH-1:0] c_S_ONE    = 1;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_FIM  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] w_s_nxt;
   logic [c_PW-1:0]  r_pre;
   logic [c_PW-1:0]  w_pre_nxt;
   logic             r_done;
   logic             w_done_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
         r_s     <= '0;
         r_pre   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_pre   <= w_pre_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_pre_nxt   = r_pre;
      w_done_nxt  = 1'b0;
      if (bus.load) begin
         w_s_nxt     = bus.value;
         w_pre_nxt   = '0;
         w_state_nxt = (bus.value != '0) ? c_RUN : c_IDLE;
      end else if (r_state == c_RUN && bus.sub) begin
         if (r_pre == c_PRE_MAX) begin
            w_pre_nxt = '0;
            // The zero guard keeps s saturated even if RUN were ever entered at 0.
            if (r_s != '0) begin
               w_s_nxt = r_s - c_S_ONE;
            end
            if (r_s == c_S_ONE) begin
               w_state_nxt = c_FIM;
               w_done_nxt  = 1'b1;
            end
         end else begin
            w_pre_nxt = r_pre + c_PRE_ONE;
         end
      end
   end

   always_comb begin
      bus.busy = (r_state == c_RUN);
      bus.zero = (r_s == '0);
      bus.s    = r_s;
      bus.done = r_done;
   end
endmodule

`default_nettype wire

// File: tb/tb_temporizador_9b.sv
// Self-checking bench for temporizador_9b: a TICK_DIV=1 instance driven from a
// vector table and a TICK_DIV=4 instance driven by hand-written sequences.
`default_nettype none

module tb_temporizador_9b;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   temporizador_9b_if #(.WIDTH(9)) bus1 ();
   temporizador_9b_if #(.WIDTH(9)) bus4 ();

   temporizador_9b #(.WIDTH(9), .TICK_DIV(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   temporizador_9b #(.WIDTH(9), .TICK_DIV(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   typedef struct {
      logic       rst;
      logic       load;
      logic [8:0] value;
      logic       sub;
      logic [8:0] s;
      logic       zero;
      logic       busy;
      logic       done;
   } vec_t;

   typedef struct {
      int         dut;
      logic [8:0] s;
      logic       zero;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t v(logic r, logic l, logic [8:0] val, logic sb_,
                              logic [8:0] es, logic ed);
      vec_t t;
      t.rst = r; t.load = l; t.value = val; t.sub = sb_;
      t.s = es; t.zero = (es == 9'd0); t.done = ed;
      // The timer is running exactly when it holds a nonzero count.
      t.busy = (es != 9'd0);
      return t;
   endfunction

   task automatic check_pop();
      exp_t       e;
      logic [8:0] as;
      logic       az, ab, ad;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      e = sb.pop_front();
      if (e.dut == 1) begin
         as = bus1.s; az = bus1.zero; ab = bus1.busy; ad = bus1.done;
      end else begin
         as = bus4.s; az = bus4.zero; ab = bus4.busy; ad = bus4.done;
      end
      checks++;
      if (as !== e.s || az !== e.zero || ab !== e.busy || ad !== e.done) begin
         failures++;
         $display("FAIL %s: got s=%0d zero=%b busy=%b done=%b, want s=%0d zero=%b busy=%b done=%b",
                  e.name, as, az, ab, ad, e.s, e.zero, e.busy, e.done);
      end
   endtask

   // Drives one cycle on the TICK_DIV=4 instance and queues its expected outputs.
   task automatic step4(logic l, logic [8:0] val, logic sb_, logic [8:0] es,
                        logic eb, logic ed, string nm);
      exp_t e;
      @(negedge clk);
      reset = 1'b0;
      bus1.load = 1'b0; bus1.sub = 1'b0;
      bus4.load = l; bus4.value = val; bus4.sub = sb_;
      e.dut = 4; e.s = es; e.zero = (es == 9'd0); e.busy = eb; e.done = ed; e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      exp_t e;
      reset = 1'b1;
      bus1.load = 1'b0; bus1.value = '0; bus1.sub = 1'b0;
      bus4.load = 1'b0; bus4.value = '0; bus4.sub = 1'b0;

      // reset beats load
      vecs.push_back(v(1, 1, 9'd100, 0, 9'd0, 0));
      vecs.push_back(v(1, 1, 9'd100, 0, 9'd0, 0));
      // idle ignores sub
      vecs.push_back(v(0, 0, 9'd0,   1, 9'd0, 0));
      // basic countdown from 5, then saturation in FIM
      vecs.push_back(v(0, 1, 9'd5, 0, 9'd5, 0));
      for (int k = 4; k >= 1; k--) vecs.push_back(v(0, 0, 9'd0, 1, 9'(k), 0));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd0, 1));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd0, 0));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd0, 0));
      // pause at 7, then resume
      vecs.push_back(v(0, 1, 9'd10, 0, 9'd10, 0));
      for (int k = 9; k >= 7; k--) vecs.push_back(v(0, 0, 9'd0, 1, 9'(k), 0));
      for (int k = 0; k < 4; k++)  vecs.push_back(v(0, 0, 9'd0, 0, 9'd7, 0));
      for (int k = 6; k >= 1; k--) vecs.push_back(v(0, 0, 9'd0, 1, 9'(k), 0));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd0, 1));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd0, 0));
      // load wins over sub, reload in RUN, load of zero
      vecs.push_back(v(0, 1, 9'd9,  1, 9'd9, 0));
      vecs.push_back(v(0, 0, 9'd0,  1, 9'd8, 0));
      vecs.push_back(v(0, 0, 9'd0,  1, 9'd7, 0));
      vecs.push_back(v(0, 1, 9'd20, 1, 9'd20, 0));
      vecs.push_back(v(0, 0, 9'd0,  1, 9'd19, 0));
      vecs.push_back(v(0, 1, 9'd0,  1, 9'd0, 0));
      vecs.push_back(v(0, 0, 9'd0,  1, 9'd0, 0));
      // reset mid-count, then a normal short interval
      vecs.push_back(v(0, 1, 9'd50, 0, 9'd50, 0));
      for (int k = 49; k >= 42; k--) vecs.push_back(v(0, 0, 9'd0, 1, 9'(k), 0));
      vecs.push_back(v(1, 0, 9'd0, 1, 9'd0, 0));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd0, 0));
      vecs.push_back(v(0, 1, 9'd2, 0, 9'd2, 0));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd1, 0));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd0, 1));
      vecs.push_back(v(0, 0, 9'd0, 1, 9'd0, 0));
      // maximum value
      vecs.push_back(v(0, 1, 9'd511, 1, 9'd511, 0));
      vecs.push_back(v(0, 0, 9'd0,   1, 9'd510, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset     = vecs[i].rst;
         bus1.load = vecs[i].load; bus1.value = vecs[i].value; bus1.sub = vecs[i].sub;
         bus4.load = 1'b0; bus4.sub = 1'b0;
         e.dut = 1; e.s = vecs[i].s; e.zero = vecs[i].zero;
         e.busy = vecs[i].busy; e.done = vecs[i].done;
         e.name = $sformatf("vec%0d", i);
         sb.push_back(e);
         @(posedge clk);
         #1;
         check_pop();
      end

      // TICK_DIV=4: load 3, done 12 enabled edges later
      step4(1, 9'd3, 0, 9'd3, 1, 0, "div4_load3");
      for (int k = 1; k <= 12; k++)
         step4(0, 9'd0, 1, 9'(3 - k / 4), k < 12, k == 12, $sformatf("div4_tick%0d", k));
      step4(0, 9'd0, 1, 9'd0, 0, 0, "div4_fim_hold");
      // 511 decrements to 510 after four enabled edges
      step4(1, 9'd511, 0, 9'd511, 1, 0, "div4_load511");
      for (int k = 1; k <= 4; k++)
         step4(0, 9'd0, 1, (k == 4) ? 9'd510 : 9'd511, 1, 0, $sformatf("div4_max%0d", k));
      // reload clears a partially advanced prescaler
      step4(1, 9'd5, 0, 9'd5, 1, 0, "div4_load5");
      step4(0, 9'd0, 1, 9'd5, 1, 0, "div4_pre1");
      step4(0, 9'd0, 1, 9'd5, 1, 0, "div4_pre2");
      step4(1, 9'd5, 1, 9'd5, 1, 0, "div4_reload");
      for (int k = 1; k <= 4; k++)
         step4(0, 9'd0, 1, (k == 4) ? 9'd4 : 9'd5, 1, 0, $sformatf("div4_after_reload%0d", k));
      // sub=0 holds the prescaler as well as the count
      step4(0, 9'd0, 1, 9'd4, 1, 0, "div4_p1");
      step4(0, 9'd0, 0, 9'd4, 1, 0, "div4_pause1");
      step4(0, 9'd0, 0, 9'd4, 1, 0, "div4_pause2");
      step4(0, 9'd0, 1, 9'd4, 1, 0, "div4_p2");
      step4(0, 9'd0, 1, 9'd4, 1, 0, "div4_p3");
      step4(0, 9'd0, 1, 9'd3, 1, 0, "div4_p4");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
